// File: rtl/dram_request_arbiter_pkg.sv
// Shared constants and state encoding for the DRAM request arbiter.
// Holds the address-FIFO command codes, burst length and FSM states.
package dram_request_arbiter_pkg;

  localparam logic [2:0] AF_CMD_WRITE = 3'b000;
  localparam logic [2:0] AF_CMD_READ  = 3'b001;

  localparam int BURST_BEATS = 2;
  localparam int ADDR_W      = 31;
  localparam int BEAT_W      = 128;
  localparam int MASK_W      = 16;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_WD0,
    ARB_WD1,
    ARB_CMD
  } arb_state_e;

endpackage

// File: rtl/dram_request_arbiter_tag_fifo.sv
// In-order tag FIFO: remembers which port issued each outstanding read.
// Ports: clk, rst, push/din, pop/dout, full, empty. Push and pop may coincide.
module arb_tag_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [PW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == (PW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rp];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + PW'(1);
      if (do_pop)  rp <= rp + PW'(1);
      cnt <= cnt + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

endmodule

// File: rtl/dram_request_arbiter.sv
// Arbitrates DRAM address/write-data FIFOs among NREQ ports and steers read data back.
// Ports: req_* per requester, af_*/wdf_*/rdf_* to the DRAM FIFOs, rd_* return, err_orphan.
module dram_request_arbiter
  import dram_request_arbiter_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int TAG_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_write,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*BEAT_W-1:0]   req_wdata,
  input  logic [NREQ*MASK_W-1:0]   req_wmask,
  output logic [NREQ-1:0]          wd_next,
  input  logic                     af_full,
  output logic                     af_wr_en,
  output logic [2:0]               af_cmd_din,
  output logic [ADDR_W-1:0]        af_addr_din,
  input  logic                     wdf_full,
  output logic                     wdf_wr_en,
  output logic [BEAT_W-1:0]        wdf_din,
  output logic [MASK_W-1:0]        wdf_mask_din,
  input  logic                     rdf_valid,
  input  logic [BEAT_W-1:0]        rdf_dout,
  output logic                     rdf_rd_en,
  output logic [NREQ-1:0]          rd_valid,
  output logic [BEAT_W-1:0]        rd_data,
  output logic                     err_orphan
);

  localparam int IW = $clog2(NREQ);

  arb_state_e      state;
  arb_state_e      state_nx;
  logic [IW-1:0]   gnt;
  logic [IW-1:0]   rr;
  logic            gwrite;
  logic [ADDR_W-1:0] gaddr;
  logic [NREQ-1:0] elig;
  logic            found;
  logic [IW-1:0]   pick;
  logic            tag_full;
  logic            tag_empty;
  logic            tag_push;
  logic            tag_pop;
  logic [IW-1:0]   tag_head;
  logic            beat;

  assign rdf_rd_en = 1'b1;

  always_comb begin
    for (int i = 0; i < NREQ; i++)
      elig[i] = req_valid[i] && (req_write[i] || !tag_full);
  end

  // Port 0 wins outright; ports 1..NREQ-1 are scanned from rr, wrapping to 1.
  always_comb begin
    int p;
    p     = 0;
    found = 1'b0;
    pick  = '0;
    if (elig[0]) begin
      found = 1'b1;
    end else begin
      for (int k = 0; k < NREQ-1; k++) begin
        p = int'(rr) + k;
        if (p >= NREQ) p = p - (NREQ-1);
        if (!found && elig[IW'(p)]) begin
          found = 1'b1;
          pick  = IW'(p);
        end
      end
    end
  end

  always_comb begin
    state_nx     = state;
    req_ready    = '0;
    wd_next      = '0;
    af_wr_en     = 1'b0;
    af_cmd_din   = '0;
    af_addr_din  = '0;
    wdf_wr_en    = 1'b0;
    wdf_din      = '0;
    wdf_mask_din = '0;
    tag_push     = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        if (found)
          state_nx = req_write[pick] ? ARB_WD0 : ARB_CMD;
      end
      ARB_WD0, ARB_WD1: begin
        wdf_wr_en    = !wdf_full;
        wdf_din      = req_wdata[BEAT_W*gnt +: BEAT_W];
        wdf_mask_din = req_wmask[MASK_W*gnt +: MASK_W];
        if (!wdf_full) begin
          wd_next[gnt] = 1'b1;
          state_nx = (state == ARB_WD0) ? ARB_WD1 : ARB_CMD;
        end
      end
      ARB_CMD: begin
        af_wr_en    = !af_full;
        af_cmd_din  = gwrite ? AF_CMD_WRITE : AF_CMD_READ;
        af_addr_din = gaddr;
        if (!af_full) begin
          req_ready[gnt] = 1'b1;
          tag_push       = !gwrite;
          state_nx       = ARB_IDLE;
        end
      end
      default: state_nx = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ARB_IDLE;
      gnt    <= '0;
      gwrite <= 1'b0;
      gaddr  <= '0;
      rr     <= IW'(1);
    end else begin
      state <= state_nx;
      if (state == ARB_IDLE && found) begin
        gnt    <= pick;
        gwrite <= req_write[pick];
        gaddr  <= req_addr[ADDR_W*pick +: ADDR_W];
      end
      if (state == ARB_CMD && !af_full && gnt != '0)
        rr <= (gnt == IW'(NREQ-1)) ? IW'(1) : gnt + IW'(1);
    end
  end

  arb_tag_fifo #(
    .W     (IW),
    .DEPTH (TAG_DEPTH)
  ) u_tags (
    .clk   (clk),
    .rst   (rst),
    .push  (tag_push),
    .din   (gnt),
    .pop   (tag_pop),
    .dout  (tag_head),
    .full  (tag_full),
    .empty (tag_empty)
  );

  // The head tag retires on the last beat of its burst.
  assign tag_pop = rdf_valid && !tag_empty &&
                   (beat == 1'(BURST_BEATS-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid   <= '0;
      rd_data    <= '0;
      beat       <= 1'b0;
      err_orphan <= 1'b0;
    end else begin
      rd_valid <= '0;
      if (rdf_valid) begin
        if (tag_empty) begin
          err_orphan <= 1'b1;
        end else begin
          rd_valid <= NREQ'(1) << tag_head;
          rd_data  <= rdf_dout;
          beat     <= ~beat;
        end
      end
    end
  end

endmodule

// File: tb/tb_dram_request_arbiter.sv
// Self-checking bench for dram_request_arbiter: cycle model plus directed scenarios.
// Compares every output each cycle and pins key behaviours with literal values.
module tb_dram_request_arbiter;

  localparam int NREQ = 4;
  localparam int TD   = 4;

  logic clk = 1'b0;
  logic rst;
  logic [NREQ-1:0] req_valid, req_write, req_ready, wd_next, rd_valid;
  logic [31*NREQ-1:0]  req_addr;
  logic [128*NREQ-1:0] req_wdata;
  logic [16*NREQ-1:0]  req_wmask;
  logic af_full, af_wr_en, wdf_full, wdf_wr_en;
  logic rdf_valid, rdf_rd_en, err_orphan;
  logic [2:0]   af_cmd_din;
  logic [30:0]  af_addr_din;
  logic [127:0] wdf_din, rdf_dout, rd_data;
  logic [15:0]  wdf_mask_din;

  dram_request_arbiter #(.NREQ(NREQ), .TAG_DEPTH(TD)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_ready(req_ready),
    .req_wdata(req_wdata), .req_wmask(req_wmask),
    .wd_next(wd_next),
    .af_full(af_full), .af_wr_en(af_wr_en),
    .af_cmd_din(af_cmd_din), .af_addr_din(af_addr_din),
    .wdf_full(wdf_full), .wdf_wr_en(wdf_wr_en),
    .wdf_din(wdf_din), .wdf_mask_din(wdf_mask_din),
    .rdf_valid(rdf_valid), .rdf_dout(rdf_dout),
    .rdf_rd_en(rdf_rd_en),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1);
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name,
                       input logic [127:0] act,
                       input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic checki(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // requester generator
  int           rem [NREQ];
  logic         dir_wr [NREQ];
  logic [30:0]  base [NREQ];
  logic [127:0] wd0 [NREQ];
  logic [127:0] wd1 [NREQ];
  logic [15:0]  wm0 [NREQ];
  logic [15:0]  wm1 [NREQ];
  logic         bsel [NREQ];
  logic [NREQ-1:0] ready_seen, wdn_seen;
  logic auto_rd;

  // model state
  int   mphase, mg, mrr, cyc;
  logic mwr, mbeat, merr;
  logic [30:0]  maddr;
  logic [NREQ-1:0] mrdv;
  logic [127:0] mrdd;
  int   tagq [$];

  // event logs
  typedef struct {
    int port;
    logic [2:0] cmd;
    logic [30:0] addr;
    int cyc;
  } af_t;
  af_t aflog [$];
  logic [127:0] wdf_d [$];
  logic [15:0]  wdf_m [$];
  int   wdf_c [$];
  int   rd_p [$];
  logic [127:0] rd_d [$];
  int   wdn_cnt [NREQ];

  function automatic int oh2i(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int mpick();
    if (req_valid[0] && (req_write[0] || tagq.size() < TD))
      return 0;
    for (int k = 0; k < NREQ-1; k++) begin
      int p;
      p = 1 + (mrr - 1 + k) % (NREQ-1);
      if (req_valid[p] && (req_write[p] || tagq.size() < TD))
        return p;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    logic [NREQ-1:0] e_rdy, e_wdn;
    logic e_af, e_wdf;
    int w;
    cyc++;
    ready_seen = req_ready;
    wdn_seen   = wd_next;
    if (af_wr_en)
      aflog.push_back('{oh2i(req_ready), af_cmd_din, af_addr_din, cyc});
    if (wdf_wr_en) begin
      wdf_d.push_back(wdf_din);
      wdf_m.push_back(wdf_mask_din);
      wdf_c.push_back(cyc);
    end
    for (int i = 0; i < NREQ; i++) if (wd_next[i]) wdn_cnt[i]++;
    if (rd_valid != '0) begin
      rd_p.push_back(oh2i(rd_valid));
      rd_d.push_back(rd_data);
    end
    if (rst) begin
      mphase = 0; mrr = 1; mbeat = 1'b0; merr = 1'b0;
      mrdv = '0; mrdd = '0;
      tagq.delete();
      check("rst_hs", 128'({req_ready, wd_next}), 128'(0));
      check("rst_af", 128'({af_wr_en, af_cmd_din, af_addr_din}), 128'(0));
      check("rst_wdf", 128'({wdf_wr_en, wdf_mask_din}), 128'(0));
      check("rst_wdfd", wdf_din, 128'(0));
      check("rst_rd", 128'({rd_valid, err_orphan}), 128'(0));
      check("rst_rdd", rd_data, 128'(0));
      check("rst_rden", 128'(rdf_rd_en), 128'(1));
    end else begin
      e_rdy = '0; e_wdn = '0; e_af = 1'b0; e_wdf = 1'b0;
      w = (mphase == 0) ? mpick() : -1;
      if (mphase == 1 || mphase == 2) begin
        e_wdf = !wdf_full;
        if (e_wdf) e_wdn[mg] = 1'b1;
      end
      if (mphase == 3) begin
        e_af = !af_full;
        if (e_af) e_rdy[mg] = 1'b1;
      end
      check("req_ready", 128'(req_ready), 128'(e_rdy));
      check("wd_next", 128'(wd_next), 128'(e_wdn));
      check("af_wr_en", 128'(af_wr_en), 128'(e_af));
      check("wdf_wr_en", 128'(wdf_wr_en), 128'(e_wdf));
      check("rdf_rd_en", 128'(rdf_rd_en), 128'(1));
      check("rd_valid", 128'(rd_valid), 128'(mrdv));
      check("err_orphan", 128'(err_orphan), 128'(merr));
      if (mrdv != '0) check("rd_data", rd_data, mrdd);
      if (mphase == 3) begin
        check("af_cmd", 128'(af_cmd_din), 128'(mwr ? 3'b000 : 3'b001));
        check("af_addr", 128'(af_addr_din), 128'(maddr));
      end
      if (mphase == 1 || mphase == 2) begin
        check("wdf_din", wdf_din, req_wdata[128*mg +: 128]);
        check("wdf_mask", 128'(wdf_mask_din), 128'(req_wmask[16*mg +: 16]));
      end
      // return path sees the queue before this cycle's push
      if (rdf_valid) begin
        if (tagq.size() == 0) begin
          merr = 1'b1;
          mrdv = '0;
        end else begin
          mrdv = 4'b0001 << tagq[0];
          mrdd = rdf_dout;
          if (mbeat) void'(tagq.pop_front());
          mbeat = ~mbeat;
        end
      end else begin
        mrdv = '0;
      end
      case (mphase)
        0: if (w >= 0) begin
          mg = w; mwr = req_write[w];
          maddr = req_addr[31*w +: 31];
          mphase = mwr ? 1 : 3;
        end
        1: if (e_wdf) mphase = 2;
        2: if (e_wdf) mphase = 3;
        3: if (e_af) begin
          if (!mwr) tagq.push_back(mg);
          if (mg != 0) mrr = (mg == NREQ-1) ? 1 : mg + 1;
          mphase = 0;
        end
        default: mphase = 0;
      endcase
    end
  end

  task automatic drive_reqs();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = rem[i] > 0;
      req_write[i] = dir_wr[i];
      req_addr[31*i +: 31] = base[i];
      req_wdata[128*i +: 128] = bsel[i] ? wd1[i] : wd0[i];
      req_wmask[16*i +: 16]   = bsel[i] ? wm1[i] : wm0[i];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (ready_seen[i]) begin
        rem[i]--;
        base[i] = base[i] + 31'd1;
        bsel[i] = 1'b0;
      end
      if (wdn_seen[i]) bsel[i] = ~bsel[i];
    end
    if (auto_rd) begin
      rdf_valid = tagq.size() > 0;
      rdf_dout  = {$urandom, $urandom, $urandom, $urandom};
    end
    drive_reqs();
  endtask

  task automatic wait_af(input int n);
    int k;
    k = 0;
    while (aflog.size() < n && k < 300) begin
      tick();
      k++;
    end
    checki("wait_af", aflog.size() >= n ? 1 : 0, 1);
  endtask

  task automatic drain();
    int k;
    k = 0;
    auto_rd = 1'b1;
    while ((tagq.size() > 0 || rdf_valid) && k < 300) begin
      tick();
      k++;
    end
    auto_rd = 1'b0;
    rdf_valid = 1'b0;
    tick();
    checki("drain_bound", k < 300 ? 1 : 0, 1);
  endtask

  task automatic beats(input int n);
    for (int i = 0; i < n; i++) begin
      rdf_valid = 1'b1;
      rdf_dout  = {32'hBEA7_0000 + i, 96'h0};
      tick();
    end
    rdf_valid = 1'b0;
  endtask

  initial begin
    int a0, r0, w0, n, k;
    int exp_rr [10];
    int exp_5 [5];
    int exp_t [10];
    rst = 1'b1;
    af_full = 1'b0; wdf_full = 1'b0;
    rdf_valid = 1'b0; rdf_dout = '0; auto_rd = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      rem[i] = 0; dir_wr[i] = 1'b0; base[i] = '0;
      wd0[i] = '0; wd1[i] = '0; wm0[i] = '0; wm1[i] = '0;
      bsel[i] = 1'b0; wdn_cnt[i] = 0;
    end
    drive_reqs();
    repeat (3) tick();
    check("reset_rden", 128'(rdf_rd_en), 128'(1));
    check("reset_af", 128'(af_wr_en), 128'(0));
    rst = 1'b0;
    tick();

    // single read, port 2
    base[2] = 31'h0010_0000; dir_wr[2] = 1'b0; rem[2] = 1;
    drive_reqs();
    wait_af(1);
    if (aflog.size() >= 1) begin
      checki("rd1_port", aflog[0].port, 2);
      check("rd1_cmd", 128'(aflog[0].cmd), 128'(3'b001));
      check("rd1_addr", 128'(aflog[0].addr), 128'(31'h0010_0000));
    end
    tick();
    r0 = rd_p.size();
    rdf_valid = 1'b1; rdf_dout = 128'hAAAA_0001;
    tick();
    rdf_dout = 128'hBBBB_0002;
    tick();
    rdf_valid = 1'b0;
    repeat (3) tick();
    checki("rd1_beats", rd_p.size() - r0, 2);
    if (rd_p.size() - r0 == 2) begin
      checki("rd1_tagA", rd_p[r0], 2);
      checki("rd1_tagB", rd_p[r0+1], 2);
      check("rd1_A", rd_d[r0], 128'hAAAA_0001);
      check("rd1_B", rd_d[r0+1], 128'hBBBB_0002);
    end

    // single write, port 3
    a0 = aflog.size(); w0 = wdf_d.size(); n = wdn_cnt[3];
    wd0[3] = {4{32'h1111_2222}}; wm0[3] = 16'h0000;
    wd1[3] = {4{32'h3333_4444}}; wm1[3] = 16'hFFFF;
    base[3] = 31'h0000_0ABC; dir_wr[3] = 1'b1; rem[3] = 1;
    drive_reqs();
    wait_af(a0 + 1);
    tick();
    checki("wr_beats", wdf_d.size() - w0, 2);
    checki("wr_wdnext", wdn_cnt[3] - n, 2);
    if (wdf_d.size() - w0 == 2 && aflog.size() > a0) begin
      check("wr_X", wdf_d[w0], {4{32'h1111_2222}});
      check("wr_Y", wdf_d[w0+1], {4{32'h3333_4444}});
      check("wr_mX", 128'(wdf_m[w0]), 128'(16'h0000));
      check("wr_mY", 128'(wdf_m[w0+1]), 128'(16'hFFFF));
      check("wr_cmd", 128'(aflog[a0].cmd), 128'(3'b000));
      checki("wr_port", aflog[a0].port, 3);
      checki("wr_order", aflog[a0].cyc > wdf_c[w0+1] ? 1 : 0, 1);
    end
    dir_wr[3] = 1'b0;

    // round robin among 1..3, port 0 cuts in
    exp_rr = '{1, 2, 3, 0, 1, 2, 3, 1, 2, 3};
    a0 = aflog.size();
    for (int p = 1; p < NREQ; p++) begin
      dir_wr[p] = 1'b0; rem[p] = 3; base[p] = 31'(p * 32'h100);
    end
    auto_rd = 1'b1;
    drive_reqs();
    k = 0;
    while (aflog.size() < a0 + 3 && k < 300) begin
      tick();
      k++;
    end
    dir_wr[0] = 1'b0; rem[0] = 1; base[0] = 31'h0000_7000;
    drive_reqs();
    wait_af(a0 + 10);
    if (aflog.size() >= a0 + 10)
      for (int i = 0; i < 10; i++)
        checki($sformatf("rr_order%0d", i), aflog[a0+i].port, exp_rr[i]);
    drain();

    // af_full stall in ARB_CMD
    a0 = aflog.size();
    af_full = 1'b1;
    dir_wr[1] = 1'b0; rem[1] = 1; base[1] = 31'h0005_5555;
    drive_reqs();
    repeat (7) tick();
    checki("afull_hold", aflog.size() - a0, 0);
    af_full = 1'b0;
    repeat (4) tick();
    checki("afull_once", aflog.size() - a0, 1);
    if (aflog.size() > a0)
      check("afull_addr", 128'(aflog[a0].addr), 128'(31'h0005_5555));
    drain();

    // five reads, tag FIFO fills; rr pointer now at 2
    exp_5 = '{2, 3, 1, 2, 1};
    exp_t = '{2, 2, 3, 3, 1, 1, 2, 2, 1, 1};
    a0 = aflog.size(); r0 = rd_p.size();
    rem[1] = 2; rem[2] = 2; rem[3] = 1;
    drive_reqs();
    wait_af(a0 + 4);
    repeat (10) tick();
    checki("stall5", aflog.size() - a0, 4);
    beats(2);
    wait_af(a0 + 5);
    if (aflog.size() >= a0 + 5)
      for (int i = 0; i < 5; i++)
        checki($sformatf("five_order%0d", i), aflog[a0+i].port, exp_5[i]);
    beats(8);
    repeat (3) tick();
    checki("five_beats", rd_p.size() - r0, 10);
    if (rd_p.size() - r0 == 10)
      for (int i = 0; i < 10; i++)
        checki($sformatf("five_tag%0d", i), rd_p[r0+i], exp_t[i]);

    // reset while in ARB_WD1
    n = wdn_cnt[2];
    wd0[2] = 128'h5A5A; wd1[2] = 128'hA5A5;
    dir_wr[2] = 1'b1; rem[2] = 1;
    drive_reqs();
    k = 0;
    while (wdn_cnt[2] < n + 1 && k < 50) begin
      tick();
      k++;
    end
    checki("wd1_reached", wdn_cnt[2] - n, 1);
    rst = 1'b1;
    #1;
    check("rstwd1_wdf", 128'({wdf_wr_en, wd_next}), 128'(0));
    check("rstwd1_af", 128'({af_wr_en, req_ready}), 128'(0));
    check("rstwd1_rden", 128'(rdf_rd_en), 128'(1));
    rem[2] = 0; bsel[2] = 1'b0; dir_wr[2] = 1'b0;
    drive_reqs();
    tick();
    rst = 1'b0;
    tick();
    r0 = rd_p.size();
    beats(2);
    repeat (2) tick();
    checki("orphan_rdv", rd_p.size() - r0, 0);
    check("orphan_err", 128'(err_orphan), 128'(1));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/dram_request_arbiter.md
Name: dram_request_arbiter

Overview:
Shares the single DRAM request interface (address FIFO, write-data FIFO, read-data FIFO) between the graphics-side requesters: pixel feeder (port 0), graphics-processor command fetch, line engine and frame filler. Port 0 has fixed top priority; the remaining ports rotate round-robin. Each transaction is a 2-beat burst of 128 bits. Read data is steered back to its issuer through an in-order tag FIFO.

Parameters:
NREQ, 4, number of requester ports (port 0 = fixed highest priority)
TAG_DEPTH, 4, max outstanding read bursts (power of 2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
req_valid  in  NREQ  request pending; held until granted
req_write  in  NREQ  1 = write burst, 0 = read burst
req_addr  in  NREQ*31  burst address per port, slice i = [31*i+30:31*i]
req_ready  out  NREQ  one-cycle pulse when port i's af entry is accepted
req_wdata  in  NREQ*128  current write beat per port
req_wmask  in  NREQ*16  byte mask for the current beat (1 = masked)
wd_next  out  NREQ  one-cycle pulse: the current beat of port i was consumed
af_full  in  1  address FIFO full
af_wr_en  out  1  address FIFO push
af_cmd_din  out  3  3'b000 write, 3'b001 read
af_addr_din  out  31  address FIFO data
wdf_full  in  1  write-data FIFO full
wdf_wr_en  out  1  write-data FIFO push
wdf_din  out  128  write beat
wdf_mask_din  out  16  write mask
rdf_valid  in  1  read beat available
rdf_dout  in  128  read beat
rdf_rd_en  out  1  tied to 1; requesters must always accept read data
rd_valid  out  NREQ  one-hot: the current rd_data belongs to port i
rd_data  out  128  registered copy of rdf_dout
err_orphan  out  1  sticky flag: rdf beat arrived with the tag FIFO empty

Behaviour:
- Reset is asynchronous. It forces state to ARB_IDLE, clears the tag FIFO, sets the RR pointer to port 1, and clears the beat counter and err_orphan. All outputs are 0 during reset except rdf_rd_en = 1.
- State machine:
  - ARB_IDLE: evaluate eligible ports.
    - A port is eligible when req_valid[i] is high, and, for a read, the tag FIFO is not full.
    - Port 0 wins whenever eligible. Otherwise take the first eligible port at or after the RR pointer, wrapping, skipping port 0.
    - Latch the grant index, direction and address.
    - A write goes to ARB_WD0; a read goes to ARB_CMD.
    - No eligible port: stay in ARB_IDLE.
  - ARB_WD0 / ARB_WD1: drive wdf_din and wdf_mask_din from the granted port's slices.
    - wdf_wr_en = !wdf_full.
    - When pushed, pulse wd_next[g] that cycle and advance.
    - The requester presents beat 1 in the cycle after the beat-0 wd_next.
    - ARB_WD1 goes to ARB_CMD.
  - ARB_CMD: af_wr_en = !af_full, with cmd and address from the latch.
    - When pushed: pulse req_ready[g].
    - For a read, push g into the tag FIFO in the same cycle.
    - If g != 0, set RR pointer = g+1, wrapping past NREQ-1 to 1.
    - Return to ARB_IDLE.
- Write data is always fully in the wdf before its af entry; this order is fixed.
- Grant is locked from ARB_IDLE exit until ARB_CMD completes. Deasserting req_valid mid-transaction is illegal; the arbiter ignores it and completes the burst.
- Minimum cost: 2 cycles per read issue and 4 cycles per write issue, with no back-to-back state skipping.
- Read return:
  - Each rdf_valid beat is registered into rd_data, with rd_valid = onehot(tag FIFO head) one cycle later.
  - A 1-bit beat counter toggles on every beat; the tag is popped on the second beat.
  - Return and issue are fully independent, so a tag push and pop in the same cycle are both honoured.
  - Full is judged before the pop, which is conservative.
- Orphan beat: rdf_valid with the tag FIFO empty drops the beat, keeps rd_valid at 0, sets err_orphan and leaves the counter unchanged. This is expected after a mid-flight reset.
- Reset mid-burst: the partial wdf burst is abandoned. The DRAM side must be reset alongside.

Decomposition:
- Shared package/header (e.g. dram_cmds.vh): AF_CMD_WRITE = 3'b000, AF_CMD_READ = 3'b001, arbiter state encodings, BURST_BEATS = 2.
- One sub-module, arb_tag_fifo: synchronous FIFO of $clog2(NREQ)-bit tags, depth TAG_DEPTH, with full/empty and simultaneous push/pop.

Test Plan:
- Single read, port 2 at addr 31'h0010_0000:
  - af_cmd_din = 001 with that address, and req_ready[2] pulses.
  - Then 2 rdf beats A, B give rd_valid = 4'b0100 twice, with rd_data = A then B.
- Single write, port 3, beats X/Y, masks 0/16'hFFFF:
  - wdf gets X, then Y with the matching masks, and wd_next[3] pulses twice.
  - Then af_cmd_din = 000; the af push happens after the second wdf push.
- Ports 1, 2, 3 all reading continuously:
  - Grant order is 1, 2, 3, 1, 2, 3.
  - When port 0 asserts, it is granted at the next ARB_IDLE and the RR pointer is not disturbed.
- af_full held 5 cycles in ARB_CMD: af_wr_en stays 0 with the address stable, and req_ready pulses exactly once after release.
- Five reads issued with rdf silent: the 5th stalls until two beats return, then issues; returned tags come back in issue order.
- Assert rst during ARB_WD1, then inject 2 rdf beats: all outputs clear immediately, rd_valid stays 0 and err_orphan = 1.
